// File: rtl/mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// mem_line_ctrl
// Initiator-side controller for the line-wide dual-port main memory.
// Cache-line read and write requests arrive on valid/ready channels. Reads
// are issued on the memory read port (rcyc/raddr). The memory returns rdata
// one cycle after rcyc, and that data is returned with its tag on rsp_*.
// Writes are issued on the memory write port (wcyc/waddr/wdata) and
// acknowledged with their tag on wb_*.
//
// Each response channel has its own RSP_DEPTH-entry FIFO. A request is only
// accepted when its response is guaranteed a FIFO slot, so the FIFOs cannot
// overflow and rdata is always captured. When a read and a write target the
// same line in the same cycle, only the write is accepted. The read issues
// one cycle later and so observes the new data.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rd_valid/rd_ready/rd_addr/rd_id        read request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_id    read response channel
//   wr_valid/wr_ready/wr_addr/wr_data/wr_id write request channel
//   wb_valid/wb_ready/wb_id                write acknowledge channel
//   rcyc/raddr/rdata               memory read port
//   wcyc/waddr/wdata               memory write port
//   stat_rd/stat_wr/stat_haz       activity counters
//
// Build option: define MEM_CTRL_STATS_EN to instantiate the 32-bit wrapping
// activity counters. When it is not defined, stat_* are tied to zero.
// -----------------------------------------------------------------------------

package param_pkg;
  localparam int MAIN_MEM_AW = 32;
  localparam int MAIN_MEM_DW = 512;
endpackage

// Small synchronous FIFO. A push and a pop in the same cycle leave the count
// unchanged. Pointers wrap naturally because DEPTH is a power of two.
module mem_line_ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           pop_data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_pop_s;

  assign do_pop_s   = pop_i && (count_q != {(PW+1){1'b0}});
  assign valid_o    = (count_q != {(PW+1){1'b0}});
  assign pop_data_o = mem_q[rptr_q];
  assign count_o    = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_i, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {(PW+1){1'b0}};
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

module mem_line_ctrl #(
  parameter int MAIN_MEM_AW = param_pkg::MAIN_MEM_AW,
  parameter int MAIN_MEM_DW = param_pkg::MAIN_MEM_DW,
  parameter int ID_W        = 4,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [MAIN_MEM_AW-1:0] rd_addr,
  input  logic [ID_W-1:0]        rd_id,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [MAIN_MEM_DW-1:0] rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [MAIN_MEM_AW-1:0] wr_addr,
  input  logic [MAIN_MEM_DW-1:0] wr_data,
  input  logic [ID_W-1:0]        wr_id,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [ID_W-1:0]        wb_id,
  output logic                   rcyc,
  output logic [MAIN_MEM_AW-1:0] raddr,
  input  logic [MAIN_MEM_DW-1:0] rdata,
  output logic                   wcyc,
  output logic [MAIN_MEM_AW-1:0] waddr,
  output logic [MAIN_MEM_DW-1:0] wdata,
  output logic [31:0]            stat_rd,
  output logic [31:0]            stat_wr,
  output logic [31:0]            stat_haz
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [PW+1:0] DEPTH_C = (PW+2)'(RSP_DEPTH);

  // Read pipeline: stage 1 drives the memory, stage 2 waits for rdata.
  logic                   rcyc_q, rcyc_d;
  logic [MAIN_MEM_AW-1:0] raddr_q, raddr_d;
  logic [ID_W-1:0]        rid1_q, rid1_d;
  logic                   rvld_q, rvld_d;
  logic [ID_W-1:0]        rid2_q, rid2_d;
  // Write port registers; wid_q travels with wcyc into the ack FIFO.
  logic                   wcyc_q, wcyc_d;
  logic [MAIN_MEM_AW-1:0] waddr_q, waddr_d;
  logic [MAIN_MEM_DW-1:0] wdata_q, wdata_d;
  logic [ID_W-1:0]        wid_q, wid_d;

  logic [PW:0]                 rd_cnt_s, wb_cnt_s;
  logic [PW+1:0]               rd_used_s, wr_used_s;
  logic                        wb_pop_s, addr_clash_s;
  logic                        rd_fire_s, wr_fire_s;
  logic [ID_W+MAIN_MEM_DW-1:0] rd_head_s;

  // A read holds a credit from acceptance until its response is popped. The
  // two pipeline stages count as in flight.
  assign rd_used_s = {1'b0, rd_cnt_s} + (PW+2)'(rcyc_q) + (PW+2)'(rvld_q);
  // The write in flight (wcyc_q) is pushed next edge, so it holds a slot.
  // A pop in this same cycle frees one.
  assign wb_pop_s  = wb_valid && wb_ready;
  assign wr_used_s = {1'b0, wb_cnt_s} + (PW+2)'(wcyc_q) - (PW+2)'(wb_pop_s);
  assign wr_ready  = (wr_used_s < DEPTH_C);

  // When the write to the same line is going ahead, the read waits a cycle
  // and then sees the new data. rd_valid is not needed to gate rd_ready.
  assign addr_clash_s = wr_valid && wr_ready && (rd_addr == wr_addr);
  assign rd_ready     = (rd_used_s < DEPTH_C) && !addr_clash_s;
  assign rd_fire_s    = rd_valid && rd_ready;
  assign wr_fire_s    = wr_valid && wr_ready;

  // Request pipeline next-state. Addresses and data hold while idle.
  always_comb begin
    rcyc_d  = rd_fire_s;
    raddr_d = raddr_q;
    rid1_d  = rid1_q;
    rvld_d  = rcyc_q;
    rid2_d  = rid1_q;
    wcyc_d  = wr_fire_s;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wid_d   = wid_q;
    if (rd_fire_s) begin
      raddr_d = rd_addr;
      rid1_d  = rd_id;
    end else begin
      raddr_d = raddr_q;
      rid1_d  = rid1_q;
    end
    if (wr_fire_s) begin
      waddr_d = wr_addr;
      wdata_d = wr_data;
      wid_d   = wr_id;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wid_d   = wid_q;
    end
  end

  // Request pipeline registers. Reset discards any in-flight read or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcyc_q  <= 1'b0;
      raddr_q <= {MAIN_MEM_AW{1'b0}};
      rid1_q  <= {ID_W{1'b0}};
      rvld_q  <= 1'b0;
      rid2_q  <= {ID_W{1'b0}};
      wcyc_q  <= 1'b0;
      waddr_q <= {MAIN_MEM_AW{1'b0}};
      wdata_q <= {MAIN_MEM_DW{1'b0}};
      wid_q   <= {ID_W{1'b0}};
    end else begin
      rcyc_q  <= rcyc_d;
      raddr_q <= raddr_d;
      rid1_q  <= rid1_d;
      rvld_q  <= rvld_d;
      rid2_q  <= rid2_d;
      wcyc_q  <= wcyc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wid_q   <= wid_d;
    end
  end

  assign rcyc  = rcyc_q;
  assign raddr = raddr_q;
  assign wcyc  = wcyc_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  mem_line_ctrl_fifo #(.W(ID_W + MAIN_MEM_DW), .DEPTH(RSP_DEPTH)) u_rd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rvld_q),
    .push_data_i({rid2_q, rdata}),
    .pop_i      (rsp_ready),
    .pop_data_o (rd_head_s),
    .valid_o    (rsp_valid),
    .count_o    (rd_cnt_s)
  );

  assign rsp_id   = rd_head_s[ID_W+MAIN_MEM_DW-1:MAIN_MEM_DW];
  assign rsp_data = rd_head_s[MAIN_MEM_DW-1:0];

  mem_line_ctrl_fifo #(.W(ID_W), .DEPTH(RSP_DEPTH)) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wcyc_q),
    .push_data_i(wid_q),
    .pop_i      (wb_ready),
    .pop_data_o (wb_id),
    .valid_o    (wb_valid),
    .count_o    (wb_cnt_s)
  );

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_haz_q;
  logic        haz_s;

  // The hazard stall only counts when a read is actually being held off.
  assign haz_s = rd_valid && addr_clash_s;

  // Wrapping activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q  <= 32'd0;
      stat_wr_q  <= 32'd0;
      stat_haz_q <= 32'd0;
    end else begin
      if (rd_fire_s) stat_rd_q <= stat_rd_q + 32'd1;
      if (wr_fire_s) stat_wr_q <= stat_wr_q + 32'd1;
      if (haz_s)     stat_haz_q <= stat_haz_q + 32'd1;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_haz = stat_haz_q;
`else
  assign stat_rd  = 32'd0;
  assign stat_wr  = 32'd0;
  assign stat_haz = 32'd0;
`endif

endmodule
